// File: rtl/branch_predict_resolve.sv
// -----------------------------------------------------------------------------
// branch_predict_resolve
//
// This block combines a bimodal branch predictor with the ID-stage branch
// resolution logic, and it keeps two branch statistics counters.
//
//   - The branch history table (BHT) holds 2-bit saturating counters. The
//     table is indexed by the word-aligned PC bits and has no tags, so
//     different PCs that map to the same index share one counter.
//   - The resolver compares the forwarded operands according to funct3. It
//     then reports the actual outcome, a mispredict flag and an illegal-funct3
//     flag. All three outputs are combinational.
//   - On each legal resolution the BHT entry is trained, and it is visible on
//     the next cycle. A same-cycle read of that entry sees the old value.
//
// Resolution handshake: res_valid is a single-cycle strobe. No ready signal
// exists because the block accepts a resolution on every clock edge. A
// resolution takes effect when res_valid is high at a rising edge and
// funct3 is legal. Otherwise no state changes.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   pred_pc             fetch PC to predict
//   pred_taken          MSB of the indexed BHT counter (combinational)
//   res_valid           a branch is resolving this cycle
//   res_pc              PC of the resolving branch
//   rs1_data, rs2_data  forwarded operands
//   funct3              branch type
//   res_pred_taken      prediction that fetch used for this branch
//   res_taken           actual outcome
//   res_mispredict      legal resolution whose outcome differs from prediction
//   res_illegal         funct3 is 010/011 while res_valid is high
//   stats_clr           synchronous clear of both statistics counters
//   branch_cnt          saturating count of legal resolutions
//   mispred_cnt         saturating count of mispredicted resolutions
// -----------------------------------------------------------------------------
module branch_predict_resolve #(
    parameter int XLEN        = 32,
    parameter int BHT_ENTRIES = 64,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [XLEN-1:0]  pred_pc,
    output logic             pred_taken,
    input  logic             res_valid,
    input  logic [XLEN-1:0]  res_pc,
    input  logic [XLEN-1:0]  rs1_data,
    input  logic [XLEN-1:0]  rs2_data,
    input  logic [2:0]       funct3,
    input  logic             res_pred_taken,
    output logic             res_taken,
    output logic             res_mispredict,
    output logic             res_illegal,
    input  logic             stats_clr,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] mispred_cnt
);

    localparam int IDX_W = $clog2(BHT_ENTRIES);

    logic [1:0]       bht_q [BHT_ENTRIES];
    logic [1:0]       bht_upd_d;
    logic [IDX_W-1:0] pred_idx;
    logic [IDX_W-1:0] res_idx;

    logic             eq;
    logic             lt;
    logic             ltu;
    logic             cond;
    logic             f3_illegal;
    logic             res_legal;

    logic [CNT_W-1:0] branch_cnt_q,  branch_cnt_d;
    logic [CNT_W-1:0] mispred_cnt_q, mispred_cnt_d;

    // Bits [1:0] of the PC are ignored because instructions are word aligned.
    assign pred_idx = pred_pc[2 +: IDX_W];
    assign res_idx  = res_pc[2 +: IDX_W];

    // No bypass: this read always sees the registered counter value.
    assign pred_taken = bht_q[pred_idx][1];

    // ---------------------------------------------------------------- resolve
    assign eq  = (rs1_data == rs2_data);
    assign lt  = ($signed(rs1_data) < $signed(rs2_data));
    assign ltu = (rs1_data < rs2_data);

    always_comb begin
        cond = 1'b0;
        case (funct3)
            3'b000:  cond = eq;
            3'b001:  cond = !eq;
            3'b100:  cond = lt;
            3'b101:  cond = !lt;
            3'b110:  cond = ltu;
            3'b111:  cond = !ltu;
            default: cond = 1'b0;
        endcase
    end

    assign f3_illegal     = (funct3[2:1] == 2'b01);
    assign res_legal      = res_valid && !f3_illegal;
    assign res_illegal    = res_valid && f3_illegal;
    assign res_taken      = res_valid && cond;
    assign res_mispredict = res_legal && (res_taken != res_pred_taken);

    // ------------------------------------------------------------------- BHT
    always_comb begin
        bht_upd_d = bht_q[res_idx];
        if (res_taken) begin
            if (bht_q[res_idx] != 2'b11) bht_upd_d = bht_q[res_idx] + 2'b01;
        end else begin
            if (bht_q[res_idx] != 2'b00) bht_upd_d = bht_q[res_idx] - 2'b01;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BHT_ENTRIES; i++) bht_q[i] <= 2'b01;
        end else if (res_legal) begin
            bht_q[res_idx] <= bht_upd_d;
        end
    end

    // ------------------------------------------------------------- statistics
    always_comb begin
        branch_cnt_d  = branch_cnt_q;
        mispred_cnt_d = mispred_cnt_q;
        if (stats_clr) begin
            branch_cnt_d  = '0;
            mispred_cnt_d = '0;
        end else begin
            if (res_legal && (branch_cnt_q != {CNT_W{1'b1}}))
                branch_cnt_d = branch_cnt_q + 1'b1;
            if (res_mispredict && (mispred_cnt_q != {CNT_W{1'b1}}))
                mispred_cnt_d = mispred_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else begin
            branch_cnt_q  <= branch_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    assign branch_cnt  = branch_cnt_q;
    assign mispred_cnt = mispred_cnt_q;

endmodule

// File: tb/tb_branch_predict_resolve.sv
// -----------------------------------------------------------------------------
// tb_branch_predict_resolve
//
// Directed bench for branch_predict_resolve. Both instances are driven from
// the same stimulus:
//   - dut uses the default parameters.
//   - dut4 uses CNT_W = 4 so that the saturation of the statistics counters
//     can be reached.
// Inputs change 1 ns after a rising edge and are sampled before the next
// rising edge.
// -----------------------------------------------------------------------------
module tb_branch_predict_resolve;

    logic        clk;
    logic        rst_n;
    logic [31:0] pred_pc;
    logic        res_valid;
    logic [31:0] res_pc;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [2:0]  funct3;
    logic        res_pred_taken;
    logic        stats_clr;

    logic        pred_taken,  pred_taken4;
    logic        res_taken,   res_taken4;
    logic        res_mispredict, res_mispredict4;
    logic        res_illegal, res_illegal4;
    logic [31:0] branch_cnt,  mispred_cnt;
    logic [3:0]  branch_cnt4, mispred_cnt4;

    int errors = 0;
    int checks = 0;

    branch_predict_resolve dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .pred_pc        (pred_pc),
        .pred_taken     (pred_taken),
        .res_valid      (res_valid),
        .res_pc         (res_pc),
        .rs1_data       (rs1_data),
        .rs2_data       (rs2_data),
        .funct3         (funct3),
        .res_pred_taken (res_pred_taken),
        .res_taken      (res_taken),
        .res_mispredict (res_mispredict),
        .res_illegal    (res_illegal),
        .stats_clr      (stats_clr),
        .branch_cnt     (branch_cnt),
        .mispred_cnt    (mispred_cnt)
    );

    branch_predict_resolve #(.CNT_W(4)) dut4 (
        .clk            (clk),
        .rst_n          (rst_n),
        .pred_pc        (pred_pc),
        .pred_taken     (pred_taken4),
        .res_valid      (res_valid),
        .res_pc         (res_pc),
        .rs1_data       (rs1_data),
        .rs2_data       (rs2_data),
        .funct3         (funct3),
        .res_pred_taken (res_pred_taken),
        .res_taken      (res_taken4),
        .res_mispredict (res_mispredict4),
        .res_illegal    (res_illegal4),
        .stats_clr      (stats_clr),
        .branch_cnt     (branch_cnt4),
        .mispred_cnt    (mispred_cnt4)
    );

    // ------------------------------------------------------- clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ----------------------------------------------------------- driver tasks
    // Presents one resolution across a single rising edge, then goes idle.
    task automatic resolve(input logic [31:0] pc, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] b,
                           input logic pt);
        res_valid      = 1'b1;
        res_pc         = pc;
        funct3         = f3;
        rs1_data       = a;
        rs2_data       = b;
        res_pred_taken = pt;
        tick();
        res_valid      = 1'b0;
    endtask

    // Applies a compare combinationally with no clock edge, then checks the
    // outcome. Here res_pred_taken is 0, so the mispredict flag equals the
    // taken flag.
    task automatic cmp(input string tag, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic exp_taken);
        res_valid      = 1'b1;
        res_pc         = 32'h800;
        funct3         = f3;
        rs1_data       = a;
        rs2_data       = b;
        res_pred_taken = 1'b0;
        #1;
        check({tag, "_taken"}, {31'd0, res_taken}, {31'd0, exp_taken});
        check({tag, "_misp"},  {31'd0, res_mispredict}, {31'd0, exp_taken});
        res_valid = 1'b0;
        tick();
    endtask

    // ------------------------------------------------------------- scenarios
    initial begin
        rst_n          = 1'b0;
        pred_pc        = 32'h100;
        res_valid      = 1'b0;
        res_pc         = '0;
        rs1_data       = '0;
        rs2_data       = '0;
        funct3         = 3'b000;
        res_pred_taken = 1'b0;
        stats_clr      = 1'b0;
        #2;

        // Reset state.
        check("rst_pred",    {31'd0, pred_taken}, 32'd0);
        check("rst_bcnt",    branch_cnt, 32'd0);
        check("rst_mcnt",    mispred_cnt, 32'd0);
        // During reset, the combinational outputs still follow their inputs,
        // and a clock edge changes no state.
        res_valid = 1'b1;
        funct3    = 3'b000;
        #1;
        check("rst_comb_taken", {31'd0, res_taken}, 32'd1);
        tick();
        check("rst_hold_bcnt", branch_cnt, 32'd0);
        check("rst_hold_pred", {31'd0, pred_taken}, 32'd0);
        res_valid = 1'b0;
        #3;
        rst_n = 1'b1;
        tick();

        // Compare decode.
        cmp("blt",  3'b100, 32'hFFFF_FFFF, 32'h1, 1'b1);
        cmp("bltu", 3'b110, 32'hFFFF_FFFF, 32'h1, 1'b0);
        cmp("bge",  3'b101, 32'hFFFF_FFFF, 32'h1, 1'b0);
        cmp("bgeu", 3'b111, 32'hFFFF_FFFF, 32'h1, 1'b1);
        cmp("beq",  3'b000, 32'h1234_5678, 32'h1234_5678, 1'b1);
        cmp("bne",  3'b001, 32'h1234_5678, 32'h1234_5678, 1'b0);
        check("cmp_no_update_bcnt", branch_cnt, 32'd0);

        // Training at 0x100 (idx 0): 01 -> 10 -> 11 -> 11 -> 11 -> 10 -> 01
        pred_pc = 32'h100;
        #1;
        check("train_init", {31'd0, pred_taken}, 32'd0);
        resolve(32'h100, 3'b000, 32'd7, 32'd7, 1'b0);
        check("train_1t", {31'd0, pred_taken}, 32'd1);
        for (int i = 0; i < 3; i++) resolve(32'h100, 3'b000, 32'd7, 32'd7, 1'b0);
        check("train_4t_bcnt", branch_cnt, 32'd4);
        check("train_4t_mcnt", mispred_cnt, 32'd4);
        resolve(32'h100, 3'b001, 32'd7, 32'd7, 1'b0);
        check("train_1nt", {31'd0, pred_taken}, 32'd1);
        resolve(32'h100, 3'b001, 32'd7, 32'd7, 1'b0);
        check("train_2nt", {31'd0, pred_taken}, 32'd0);
        check("train_bcnt", branch_cnt, 32'd6);
        check("train_mcnt", mispred_cnt, 32'd4);

        // Collision at 0x40 (idx 16, counter 01). The read sees the old value.
        pred_pc        = 32'h40;
        res_valid      = 1'b1;
        res_pc         = 32'h40;
        funct3         = 3'b000;
        rs1_data       = 32'd3;
        rs2_data       = 32'd3;
        res_pred_taken = 1'b0;
        #1;
        check("coll_same_cycle", {31'd0, pred_taken}, 32'd0);
        tick();
        res_valid = 1'b0;
        check("coll_next_cycle", {31'd0, pred_taken}, 32'd1);
        // Aliasing on a PC that maps to the same index, and low bits that are ignored.
        pred_pc = 32'h140;
        #1;
        check("alias_0x140", {31'd0, pred_taken}, 32'd1);
        pred_pc = 32'h43;
        #1;
        check("lowbits_0x43", {31'd0, pred_taken}, 32'd1);
        pred_pc = 32'h44;
        #1;
        check("neighbour_0x44", {31'd0, pred_taken}, 32'd0);

        // Mispredict on a BNE with equal operands that was predicted taken.
        res_valid      = 1'b1;
        res_pc         = 32'h204;
        funct3         = 3'b001;
        rs1_data       = 32'd9;
        rs2_data       = 32'd9;
        res_pred_taken = 1'b1;
        #1;
        check("bne_misp", {31'd0, res_mispredict}, 32'd1);
        tick();
        res_valid = 1'b0;
        check("bne_bcnt", branch_cnt, 32'd8);
        check("bne_mcnt", mispred_cnt, 32'd6);

        // Illegal funct3 at 0x40 (counter 10). Nothing may change.
        pred_pc        = 32'h40;
        res_valid      = 1'b1;
        res_pc         = 32'h40;
        funct3         = 3'b010;
        res_pred_taken = 1'b1;
        #1;
        check("ill010_flag",  {31'd0, res_illegal}, 32'd1);
        check("ill010_taken", {31'd0, res_taken}, 32'd0);
        check("ill010_misp",  {31'd0, res_mispredict}, 32'd0);
        funct3 = 3'b011;
        #1;
        check("ill011_flag", {31'd0, res_illegal}, 32'd1);
        tick();
        res_valid = 1'b0;
        #1;
        check("ill_bcnt", branch_cnt, 32'd8);
        check("ill_mcnt", mispred_cnt, 32'd6);
        check("ill_bht",  {31'd0, pred_taken}, 32'd1);
        check("idle_illegal", {31'd0, res_illegal}, 32'd0);
        funct3 = 3'b000;
        #1;
        check("idle_taken", {31'd0, res_taken}, 32'd0);

        // stats_clr has priority over a concurrent mispredicted resolve.
        stats_clr = 1'b1;
        resolve(32'h208, 3'b000, 32'd1, 32'd1, 1'b0);
        stats_clr = 1'b0;
        check("clr_bcnt",  branch_cnt, 32'd0);
        check("clr_mcnt",  mispred_cnt, 32'd0);
        check("clr_bcnt4", {28'd0, branch_cnt4}, 32'd0);
        pred_pc = 32'h40;
        #1;
        check("clr_keeps_bht", {31'd0, pred_taken}, 32'd1);
        resolve(32'h20C, 3'b000, 32'd1, 32'd1, 1'b1);
        check("post_clr_bcnt", branch_cnt, 32'd1);
        check("post_clr_mcnt", mispred_cnt, 32'd0);

        // Saturation of the 4-bit statistics counters.
        for (int i = 0; i < 14; i++) resolve(32'h208, 3'b000, 32'd1, 32'd1, 1'b0);
        check("sat_pre_bcnt4", {28'd0, branch_cnt4}, 32'd15);
        check("sat_pre_mcnt4", {28'd0, mispred_cnt4}, 32'd14);
        resolve(32'h208, 3'b000, 32'd1, 32'd1, 1'b0);
        resolve(32'h208, 3'b000, 32'd1, 32'd1, 1'b0);
        check("sat_bcnt4", {28'd0, branch_cnt4}, 32'd15);
        check("sat_mcnt4", {28'd0, mispred_cnt4}, 32'd15);
        check("sat_bcnt32", branch_cnt, 32'd17);
        check("sat_mcnt32", mispred_cnt, 32'd16);

        // Asynchronous reset in the middle of operation, after idx 5 is trained to 11.
        pred_pc = 32'h14;
        resolve(32'h14, 3'b000, 32'd2, 32'd2, 1'b1);
        resolve(32'h14, 3'b000, 32'd2, 32'd2, 1'b1);
        check("idx5_trained", {31'd0, pred_taken}, 32'd1);
        res_valid = 1'b1;
        res_pc    = 32'h14;
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_pred", {31'd0, pred_taken}, 32'd0);
        check("async_rst_bcnt", branch_cnt, 32'd0);
        check("async_rst_mcnt", mispred_cnt, 32'd0);
        tick();
        check("async_rst_hold", branch_cnt, 32'd0);
        #3;
        rst_n = 1'b1;
        tick();
        res_valid = 1'b0;
        check("first_edge_pred", {31'd0, pred_taken}, 32'd1);
        check("first_edge_bcnt", branch_cnt, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
